// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding and
// flag bit positions within the internal flag register.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_NOTA  = 3'd5;
  localparam logic [2:0] OP_PASSB = 3'd6;
  localparam logic [2:0] OP_MUL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_Z = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// A start pulse loads the operands; WIDTH steps follow, after which done is
// high until the cycle the product is taken (busy then drops).
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;

  // Partial sum: add the multiplicand when the current multiplier bit is set.
  assign sum = lo[0] ? ({1'b0, hi} + {1'b0, a_q}) : {1'b0, hi};

  // Load on start, then shift the {hi, lo} pair right one bit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      hi   <= '0;
      lo   <= b;
      cnt  <= CNT_W'(WIDTH);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        hi  <= sum[WIDTH:1];
        lo  <= {sum[0], lo[WIDTH-1:1]};
        cnt <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done    = busy & (cnt == '0);
  assign product = {hi, lo};

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready operand and result handshakes.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds its data stable while valid is high and ready low.
// Optional feature macro: ALU_MUL_EN enables the iterative multiplier for
// selop=7; without it selop=7 completes in one cycle with a zero result.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   busA,
  input  logic [WIDTH-1:0]   busB,
  input  logic [2:0]         selop,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               shdir,
  input  logic               enaf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   busC,
  output logic [WIDTH-1:0]   busH,
  output logic               C,
  output logic               N,
  output logic               P,
  output logic               Z
);

  state_t             state;
  logic [SHAMT_W-1:0] shamt_q;
  logic               shdir_q;
  logic               enaf_q;
  logic [3:0]         flags;

  logic               accept;
  logic               is_mul;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               finish;

  logic [WIDTH:0]     op_sum;
  logic [WIDTH-1:0]   op_res;
  logic               op_c;

  logic [WIDTH-1:0]   sh_src;
  logic               sh_c;
  logic [SHAMT_W-1:0] sh_amt;
  logic               sh_dir;
  logic [WIDTH-1:0]   hi_src;
  logic               en_flags;
  logic [2*WIDTH-1:0] ext_l;
  logic [2*WIDTH-1:0] ext_r;
  logic [WIDTH-1:0]   res;
  logic               res_c;

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef ALU_MUL_EN
  assign is_mul = (selop == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept & is_mul),
    .a       (busA),
    .b       (busB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // A result is ready either straight from an accepted single-cycle op or
  // when the multiplier reports its final step.
  assign finish = (accept & ~is_mul) | ((state == ST_MUL) & mul_busy & mul_done);

  // Single-cycle operation on the live operands (only used on accept).
  always_comb begin
    op_sum = '0;
    op_res = '0;
    op_c   = 1'b0;
    case (selop)
      OP_ADD: begin
        op_sum = {1'b0, busA} + {1'b0, busB};
        op_res = op_sum[WIDTH-1:0];
        op_c   = op_sum[WIDTH];
      end
      OP_SUB: begin
        op_sum = {1'b0, busA} + {1'b0, ~busB} + (WIDTH+1)'(1);
        op_res = op_sum[WIDTH-1:0];
        op_c   = ~op_sum[WIDTH];
      end
      OP_AND:   op_res = busA & busB;
      OP_OR:    op_res = busA | busB;
      OP_XOR:   op_res = busA ^ busB;
      OP_NOTA:  op_res = ~busA;
      OP_PASSB: op_res = busB;
      default: begin
        op_res = '0;
        op_c   = 1'b0;
      end
    endcase
  end

  // Post-op shifter; the MUL path uses the latched shift controls.
  always_comb begin
    if (state == ST_MUL) begin
      sh_src   = mul_prod[WIDTH-1:0];
      sh_c     = |mul_prod[2*WIDTH-1:WIDTH];
      sh_amt   = shamt_q;
      sh_dir   = shdir_q;
      hi_src   = mul_prod[2*WIDTH-1:WIDTH];
      en_flags = enaf_q;
    end else begin
      sh_src   = op_res;
      sh_c     = op_c;
      sh_amt   = shamt;
      sh_dir   = shdir;
      hi_src   = '0;
      en_flags = enaf;
    end
    ext_l = {{WIDTH{1'b0}}, sh_src} << sh_amt;
    ext_r = {sh_src, {WIDTH{1'b0}}} >> sh_amt;
    if (sh_amt == '0) begin
      res   = sh_src;
      res_c = sh_c;
    end else if (sh_dir) begin
      res   = ext_r[2*WIDTH-1:WIDTH];
      res_c = ext_r[WIDTH-1];
    end else begin
      res   = ext_l[WIDTH-1:0];
      res_c = ext_l[WIDTH];
    end
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shamt_q   <= '0;
      shdir_q   <= 1'b0;
      enaf_q    <= 1'b0;
      busC      <= '0;
      busH      <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        shamt_q <= shamt;
        shdir_q <= shdir;
        enaf_q  <= enaf;
        if (is_mul) begin
          state     <= ST_MUL;
          out_valid <= 1'b0;
        end
      end
      if (finish) begin
        state     <= ST_DONE;
        out_valid <= 1'b1;
        busC      <= res;
        busH      <= hi_src;
        if (en_flags) begin
          flags[FLAG_C] <= res_c;
          flags[FLAG_N] <= res[WIDTH-1];
          flags[FLAG_Z] <= (res == '0);
          flags[FLAG_P] <= ~res[WIDTH-1] & (res != '0);
        end
      end else if (!accept && (state == ST_DONE) && out_ready) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
      end
    end
  end

  assign C = flags[FLAG_C];
  assign N = flags[FLAG_N];
  assign P = flags[FLAG_P];
  assign Z = flags[FLAG_Z];

endmodule
